// File: rtl/jk_encoder.sv
// USB full-speed line transmitter: SYNC, NRZI payload, optional bit stuffing, EOP.
// Define JK_ENCODER_STUFF_EN to enable bit stuffing (required on a real bus).
module jk_encoder #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk48,
  input  logic reset,
  input  logic tx_start,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic bit_last,
  output logic bit_ready,
  output logic dp,
  output logic dn,
  output logic oe,
  output logic tx_busy,
  output logic underrun
);
  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_PAYLOAD, S_EOP} state_t;
  typedef enum logic [1:0] {N_DATA, N_STUFF, N_EOP} next_t;

  state_t        r_state;
  next_t         r_next;
  logic [PW-1:0] r_phase;
  logic [2:0]    r_bitcnt;
  logic          r_last;
  logic          r_dp, r_dn, r_oe, r_busy, r_ready;

  logic       w_wrap, w_pre_wrap, w_data_slot, w_stuff_due, w_sync_dp;
  logic [2:0] w_sync_idx;

  assign w_wrap      = (r_phase == PW'(CLKS_PER_BIT - 1));
  assign w_pre_wrap  = (r_phase == PW'(CLKS_PER_BIT - 2));
  // The 8th SYNC period and every payload data period end by consuming a bit.
  assign w_data_slot = ((r_state == S_SYNC) && (r_bitcnt == 3'd7)) ||
                       ((r_state == S_PAYLOAD) && (r_next == N_DATA));
  assign w_sync_idx  = r_bitcnt + 3'd1;
  assign w_sync_dp   = w_sync_idx[0] & (w_sync_idx != 3'd7);

`ifdef JK_ENCODER_STUFF_EN
  logic [2:0] r_ones;
  logic [2:0] w_ones_nxt;

  assign w_ones_nxt  = bit_in ? r_ones + 3'd1 : 3'd0;
  assign w_stuff_due = (w_ones_nxt == 3'd6);

  always_ff @(posedge clk48) begin
    if (!reset) begin
      r_ones <= 3'd0;
    end else if ((r_state == S_IDLE) && tx_start) begin
      r_ones <= 3'd0;
    end else if (w_wrap && w_data_slot && bit_valid) begin
      r_ones <= w_ones_nxt;
    end else if (w_wrap && (r_state == S_PAYLOAD) && (r_next == N_STUFF)) begin
      r_ones <= 3'd0;
    end
  end
`else
  assign w_stuff_due = 1'b0;
`endif

  always_ff @(posedge clk48) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_next   <= N_DATA;
      r_phase  <= '0;
      r_bitcnt <= 3'd0;
      r_last   <= 1'b0;
      r_dp     <= 1'b1;
      r_dn     <= 1'b0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (r_state == S_IDLE) begin
        if (tx_start) begin
          r_state  <= S_SYNC;
          r_next   <= N_DATA;
          r_phase  <= '0;
          r_bitcnt <= 3'd0;
          r_last   <= 1'b0;
          r_dp     <= 1'b0;
          r_dn     <= 1'b1;
          r_oe     <= 1'b1;
          r_busy   <= 1'b1;
        end
      end else begin
        r_phase <= w_wrap ? '0 : r_phase + PW'(1);
        r_ready <= w_pre_wrap && w_data_slot;
        if (w_wrap) begin
          if (w_data_slot) begin
            if (bit_valid) begin
              // NRZI: a 0 toggles the line, a 1 holds it.
              r_state <= S_PAYLOAD;
              r_last  <= bit_last;
              if (!bit_in) begin
                r_dp <= ~r_dp;
                r_dn <= r_dp;
              end
              r_next <= w_stuff_due ? N_STUFF : (bit_last ? N_EOP : N_DATA);
            end else begin
              r_state  <= S_EOP;
              r_bitcnt <= 3'd0;
              r_dp     <= 1'b0;
              r_dn     <= 1'b0;
            end
          end else begin
            case (r_state)
              S_SYNC: begin
                r_bitcnt <= w_sync_idx;
                r_dp     <= w_sync_dp;
                r_dn     <= ~w_sync_dp;
              end
              S_PAYLOAD: begin
                if (r_next == N_STUFF) begin
                  r_dp   <= ~r_dp;
                  r_dn   <= r_dp;
                  r_next <= r_last ? N_EOP : N_DATA;
                end else begin
                  r_state  <= S_EOP;
                  r_bitcnt <= 3'd0;
                  r_dp     <= 1'b0;
                  r_dn     <= 1'b0;
                end
              end
              default: begin
                // EOP: SE0, SE0, J, then release the pads.
                if (r_bitcnt == 3'd2) begin
                  r_state <= S_IDLE;
                  r_dp    <= 1'b1;
                  r_dn    <= 1'b0;
                  r_oe    <= 1'b0;
                  r_busy  <= 1'b0;
                end else begin
                  r_bitcnt <= r_bitcnt + 3'd1;
                  if (r_bitcnt == 3'd1) begin
                    r_dp <= 1'b1;
                    r_dn <= 1'b0;
                  end
                end
              end
            endcase
          end
        end
      end
    end
  end

  assign bit_ready = r_ready;
  assign dp        = r_dp;
  assign dn        = r_dn;
  assign oe        = r_oe;
  assign tx_busy   = r_busy;
  // Flags the missing bit in the same clock as the strobe it failed to answer.
  assign underrun  = r_ready & ~bit_valid;

endmodule

// File: tb/tb_jk_encoder.sv
// Bench for jk_encoder: per-period line scoreboard built from a reference model.
module tb_jk_encoder;
  localparam int CPB = 4;
`ifdef JK_ENCODER_STUFF_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif
  localparam logic [1:0] SYM_J = 2'b10, SYM_K = 2'b01, SYM_SE0 = 2'b00;

  logic clk48 = 1'b0;
  logic reset = 1'b0, tx_start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, bit_last = 1'b0;
  logic bit_ready, dp, dn, oe, tx_busy, underrun;

  jk_encoder #(.CLKS_PER_BIT(CPB)) dut (
    .clk48(clk48), .reset(reset), .tx_start(tx_start), .bit_in(bit_in),
    .bit_valid(bit_valid), .bit_last(bit_last), .bit_ready(bit_ready),
    .dp(dp), .dn(dn), .oe(oe), .tx_busy(tx_busy), .underrun(underrun)
  );

  always #5 clk48 = ~clk48;

  typedef struct {
    string       name;
    logic [31:0] bits;
    int          n;
    bit          und;
    bit          mid_start;
    int          exp_ready;
  } vec_t;

  int checks = 0, failures = 0;
  logic [1:0] expq[$];
  bit   mon_en = 1'b0;
  int   oe_clks = 0, ready_cnt = 0, und_cnt = 0;
  logic [1:0] cur = 2'b11;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: SYNC, NRZI with optional stuffing, EOP; one entry per bit period.
  task automatic build_expected(input logic [31:0] bits, input int n, input bit und);
    logic [1:0] line;
    int ones;
    logic [1:0] sync[8] = '{SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_K};
    for (int i = 0; i < 8; i++) expq.push_back(sync[i]);
    line = SYM_K;
    ones = 0;
    if (!und) begin
      for (int i = 0; i < n; i++) begin
        if (!bits[i]) line = ~line;
        expq.push_back(line);
        ones = bits[i] ? ones + 1 : 0;
        if (STUFF && ones == 6) begin
          line = ~line;
          expq.push_back(line);
          ones = 0;
        end
      end
    end
    expq.push_back(SYM_SE0);
    expq.push_back(SYM_SE0);
    expq.push_back(SYM_J);
  endtask

  always @(negedge clk48) begin
    if (mon_en) begin
      if (oe) begin
        if (oe_clks % CPB == 0) begin
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_period actual=oe_high required=idle clk=%0d", oe_clks);
            cur = 2'b11;
          end else begin
            cur = expq.pop_front();
          end
        end
        check($sformatf("line_clk%0d", oe_clks), 32'({dp, dn}), 32'(cur));
        check("busy_with_oe", 32'(tx_busy), 32'd1);
        oe_clks++;
      end
      if (bit_ready) ready_cnt++;
      if (underrun) begin
        und_cnt++;
        check("underrun_needs_ready", 32'(bit_ready), 32'd1);
      end
    end
  end

  task automatic run_packet(input vec_t v);
    int idx;
    int exp_clks;
    bit done;
    expq.delete();
    build_expected(v.bits, v.n, v.und);
    exp_clks = CPB * expq.size();
    oe_clks = 0;
    ready_cnt = 0;
    und_cnt = 0;
    idx = 0;
    bit_in = v.bits[0];
    bit_valid = !v.und;
    bit_last = (v.n == 1);
    @(negedge clk48);
    tx_start = 1'b1;
    mon_en = 1'b1;
    @(negedge clk48);
    tx_start = 1'b0;
    check({v.name, "_start"}, 32'({oe, tx_busy, dp, dn}), 32'b1101);
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      tx_start = v.mid_start && (cyc == 40);
      if (bit_ready && bit_valid) begin
        @(posedge clk48);
        #1;
        idx++;
        bit_in = v.bits[idx];
        bit_valid = (idx < v.n);
        bit_last = (idx == v.n - 1);
      end
      @(negedge clk48);
      if (!oe) done = 1'b1;
    end
    tx_start = 1'b0;
    mon_en = 1'b0;
    bit_valid = 1'b0;
    bit_last = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=oe_stuck_high required=return_to_idle", v.name);
    end
    check({v.name, "_oe_clocks"}, 32'(oe_clks), 32'(exp_clks));
    check({v.name, "_ready_pulses"}, 32'(ready_cnt), 32'(v.exp_ready));
    check({v.name, "_underruns"}, 32'(und_cnt), 32'(v.und));
    check({v.name, "_periods_left"}, 32'(expq.size()), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{"a5",       32'h0000_00A5, 8,  1'b0, 1'b0, 8};
    vecs[1] = '{"ones7",    32'h0000_007F, 7,  1'b0, 1'b0, 7};
    vecs[2] = '{"ones6",    32'h0000_003F, 6,  1'b0, 1'b0, 6};
    vecs[3] = '{"underrun", 32'h0000_0000, 1,  1'b1, 1'b0, 1};
    vecs[4] = '{"midstart", 32'h0000_0F0F, 16, 1'b0, 1'b1, 16};
    vecs[5] = '{"ones16",   32'h0000_FFFF, 16, 1'b0, 1'b0, 16};
    vecs[6] = '{"single0",  32'h0000_0000, 1,  1'b0, 1'b0, 1};

    // Reset held with tx_start asserted must keep the line idle.
    reset = 1'b0;
    tx_start = 1'b1;
    repeat (2) begin
      @(negedge clk48);
      check("reset_outputs", 32'({dp, dn, oe, tx_busy, bit_ready, underrun}), 32'b100000);
    end
    reset = 1'b1;
    tx_start = 1'b0;
    @(negedge clk48);
    check("idle_after_reset", 32'({dp, dn, oe, tx_busy}), 32'b1000);

    for (int i = 0; i < 7; i++) run_packet(vecs[i]);

    // Reset in the middle of the payload: pads released at once, no EOP.
    bit_in = 1'b0;
    bit_valid = 1'b1;
    bit_last = 1'b0;
    @(negedge clk48);
    tx_start = 1'b1;
    @(negedge clk48);
    tx_start = 1'b0;
    repeat (40) @(negedge clk48);
    check("midreset_active", 32'({oe, tx_busy}), 32'b11);
    reset = 1'b0;
    @(negedge clk48);
    check("midreset_outputs", 32'({dp, dn, oe, tx_busy, bit_ready, underrun}), 32'b100000);
    reset = 1'b1;
    bit_valid = 1'b0;
    repeat (3) begin
      @(negedge clk48);
      check("midreset_no_se0", 32'({dp, dn, oe, tx_busy}), 32'b1000);
    end

    run_packet(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jk_encoder.md
# jk_encoder

USB full-speed line transmitter running on the 48 MHz clock: the transmit-side counterpart of the bus-level JK decoder. It accepts a serial payload bit stream through a ready/valid handshake and prepends the SYNC pattern. It NRZI-encodes the bits, inserts stuff bits and appends EOP. It drives the D+/D− pins and their output enable at 12 Mb/s (4 clocks per bit), and sits between the packet serializer and the pad/IO buffer.

## Interface
- `CLKS_PER_BIT`, default 4: clocks per line bit; 4 at 48 MHz.
- `clk48` input 1: 48 MHz clock.
- `reset` input 1: synchronous, active-low reset; 0 = reset.
- `tx_start` input 1: one-clock request to begin a packet; sampled only in IDLE.
- `bit_in` input 1: payload bit, LSB-first.
- `bit_valid` input 1: `bit_in` valid.
- `bit_last` input 1: qualifies `bit_in` as the final payload bit.
- `bit_ready` output 1: one-clock strobe; the bit is consumed when `bit_ready & bit_valid`.
- `dp` output 1: D+ drive value.
- `dn` output 1: D− drive value.
- `oe` output 1: pad output enable.
- `tx_busy` output 1: high from the accepted `tx_start` until return to IDLE.
- `underrun` output 1: one-clock pulse when `bit_valid` is low at a `bit_ready` slot.

## Operation
- Line states: J = dp1/dn0; K = dp0/dn1; SE0 = dp0/dn0.
- With `oe`=0, the block drives J.
- IDLE:
  - `oe`=0.
  - On `tx_start`=1, go to SYNC and start the first bit period next clock.
- SYNC: 8 bit periods of K J K J K J K K. The line ends on K.
- PAYLOAD, per bit period:
  - Stuff slot: if the ones counter == 6, emit a toggle. No bit is consumed and the counter clears.
  - Data slot otherwise:
    - Bit 0 toggles the line; bit 1 holds it.
    - The ones counter increments on 1 and clears on 0.
- The ones counter clears entering PAYLOAD. The last SYNC K does not count.
- `bit_last` accepted: after that bit (and one stuff slot if the counter reaches 6), go to EOP.
- Underrun: `bit_valid`=0 at a `bit_ready` slot.
  - Pulse `underrun` and go to EOP at the next bit boundary.
  - The ones counter does not change.
- EOP: 2 bit periods SE0, then 1 bit period J, then `oe`=0 and IDLE.
- `tx_start` while busy is ignored.
- Reset outputs: `dp`=1, `dn`=0, `oe`=0, `bit_ready`=0, `tx_busy`=0, `underrun`=0.
- Reset mid-packet: all outputs take their reset values on the next clock, with no EOP emitted.

## Timing
- A phase counter runs 0..CLKS_PER_BIT−1 in every non-IDLE state. Line state changes only when phase wraps to 0.
- Outputs are registered.
- `tx_start` at clock n: `oe`=1 and K from clock n+1. `tx_busy` is high from n+1.
- `bit_ready` is asserted only at phase CLKS_PER_BIT−1 of:
  - the 8th SYNC bit;
  - any PAYLOAD period whose next slot is a data slot.
- It is never asserted before a stuff slot or after `bit_last` is accepted.
- An accepted bit appears on the line at the next phase 0, one clock later.
- `underrun` is asserted in the same clock as the failed `bit_ready`.
- Packet length in clocks: CLKS_PER_BIT × (8 + payload bits + stuff bits + 3). `oe` falls at the clock after the final J period.

## Configuration
- `JK_ENCODER_STUFF_EN` defined: bit stuffing as described. Required for bus use.
- `JK_ENCODER_STUFF_EN` undefined:
  - No stuff slots are inserted.
  - The ones counter is removed.
  - `bit_ready` is offered every PAYLOAD period.
  - Used for raw-NRZI loopback against the decoder.

## Test plan
1. Reset: hold `reset`=0 two clocks with `tx_start`=1 → `dp`=1, `dn`=0, `oe`=0, `tx_busy`=0 throughout.
2. Payload 0xA5 LSB-first (1,0,1,0,0,1,0,1), `bit_last` on the 8th bit:
   - SYNC K J K J K J K K, then K J J K J J K K, then SE0 SE0 J.
   - 8 `bit_ready` pulses.
   - `oe` high for exactly 76 clocks.
3. Seven 1s with `bit_last` on the 7th (stuffing on):
   - After SYNC: K×6, stuff J, J, then EOP.
   - Exactly 7 `bit_ready` pulses, none in the stuff period.
   - Six 1s then `bit_last`: the stuff J precedes SE0.
4. Underrun: `bit_valid`=0 at the first `bit_ready` → `underrun` high for 1 clock; SE0 starts at the next phase 0; `tx_busy` clears after 3 bit periods.
5. `tx_start` pulsed mid-PAYLOAD is ignored with no second SYNC. `reset`=0 mid-PAYLOAD → `oe`=0 and `dp`=1 next clock, with no SE0.
6. `JK_ENCODER_STUFF_EN` undefined, seven 1s → K×7 after SYNC, no stuff bit, 7 `bit_ready` pulses.
